// File: rtl/sound_sequencer.sv
// Priority scheduler for game sound events in front of the shared tone player.
// Latches event pulses, starts them one at a time, pre-empts on higher priority and loops a background sound when idle.
module sound_sequencer #(
    parameter int               NSRC       = 8,
    parameter int               SELW       = 3,
    parameter logic [SELW-1:0]  BG_SEL     = 3'd7,
    parameter logic [12:0]      GAP_CYCLES = 13'd4535,
    parameter logic [23:0]      TIMEOUT    = 24'hFFFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NSRC-1:0]  ev_req,
    input  logic             bg_en,
    input  logic             mute,
    input  logic             player_done,
    output logic             play_start,
    output logic             play_abort,
    output logic [SELW-1:0]  play_sel,
    output logic             busy,
    output logic [NSRC-1:0]  pending,
    output logic [7:0]       drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_PLAY  = 3'd2,
        S_ABORT = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam logic [NSRC-1:0] ZERO_MASK = {NSRC{1'b0}};
    localparam logic [NSRC-1:0] ONE_HOT0  = {{(NSRC-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_next_s;
    logic [NSRC-1:0]   pending_r;
    logic [7:0]        drop_cnt_r;
    logic [SELW-1:0]   play_sel_r;
    logic              cur_bg_r;
    logic              preempt_r;
    logic [12:0]       gap_cnt_r;
    logic [23:0]       wd_cnt_r;

    logic [SELW-1:0]   sel_idx_s;
    logic              take_ev_s;
    logic [NSRC-1:0]   clear_mask_s;
    logic              drop_hit_s;
    logic              preempt_s;
    logic              timeout_s;
    logic              gap_done_s;

    // Index of the highest-priority (lowest-numbered) set bit.
    function automatic logic [SELW-1:0] lowest_idx(input logic [NSRC-1:0] vec);
        logic [SELW-1:0] idx;
        idx = {SELW{1'b0}};
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = SELW'(i);
            end
        end
        return idx;
    endfunction

    // Mask of sources that outrank the given selector.
    function automatic logic [NSRC-1:0] higher_mask(input logic [SELW-1:0] sel);
        logic [NSRC-1:0] m;
        for (int i = 0; i < NSRC; i++) begin
            m[i] = (i < int'(sel));
        end
        return m;
    endfunction

    // Selection, coalescing and pre-emption qualifiers.
    always_comb begin
        sel_idx_s = lowest_idx(pending_r);
        take_ev_s = (state_r == S_IDLE) && !mute && (pending_r != ZERO_MASK);
        if (take_ev_s) begin
            clear_mask_s = ONE_HOT0 << sel_idx_s;
        end else begin
            clear_mask_s = ZERO_MASK;
        end
        drop_hit_s = !mute && ((ev_req & pending_r & ~clear_mask_s) != ZERO_MASK);
        // Pre-emption is registered, so a new request acts two edges after it is sampled.
        if (cur_bg_r) begin
            preempt_s = (pending_r != ZERO_MASK) || !bg_en;
        end else begin
            preempt_s = (pending_r & higher_mask(play_sel_r)) != ZERO_MASK;
        end
        timeout_s  = wd_cnt_r >= (TIMEOUT - 24'd1);
        gap_done_s = gap_cnt_r >= (GAP_CYCLES - 13'd1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; player_done outranks every abort cause.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (take_ev_s || (!mute && bg_en)) begin
                    state_next_s = S_START;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_START: state_next_s = S_PLAY;
            S_PLAY: begin
                if (player_done) begin
                    state_next_s = S_GAP;
                end else if (mute || preempt_r || timeout_s) begin
                    state_next_s = S_ABORT;
                end else begin
                    state_next_s = S_PLAY;
                end
            end
            S_ABORT: state_next_s = S_GAP;
            S_GAP: begin
                if (gap_done_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_GAP;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        play_start = 1'b0;
        play_abort = 1'b0;
        busy       = 1'b0;
        case (state_r)
            S_IDLE:  busy = 1'b0;
            S_START: begin
                play_start = 1'b1;
                busy       = 1'b1;
            end
            S_PLAY:  busy = 1'b1;
            S_ABORT: begin
                play_abort = 1'b1;
                busy       = 1'b1;
            end
            S_GAP:   busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Pending latch, drop counter, selector, pre-emption flag and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r  <= ZERO_MASK;
            drop_cnt_r <= 8'd0;
            play_sel_r <= {SELW{1'b0}};
            cur_bg_r   <= 1'b0;
            preempt_r  <= 1'b0;
            gap_cnt_r  <= 13'd0;
            wd_cnt_r   <= 24'd0;
        end else begin
            if (mute) begin
                pending_r <= ZERO_MASK;
            end else begin
                pending_r <= (pending_r & ~clear_mask_s) | ev_req;
            end
            if (drop_hit_s && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
            if ((state_r == S_IDLE) && (state_next_s == S_START)) begin
                if (take_ev_s) begin
                    play_sel_r <= sel_idx_s;
                    cur_bg_r   <= 1'b0;
                end else begin
                    play_sel_r <= BG_SEL;
                    cur_bg_r   <= 1'b1;
                end
            end
            preempt_r <= preempt_s;
            if (state_r == S_PLAY) begin
                wd_cnt_r <= wd_cnt_r + 24'd1;
            end else begin
                wd_cnt_r <= 24'd0;
            end
            if (state_r == S_GAP) begin
                gap_cnt_r <= gap_cnt_r + 13'd1;
            end else begin
                gap_cnt_r <= 13'd0;
            end
        end
    end

    assign pending  = pending_r;
    assign drop_cnt = drop_cnt_r;
    assign play_sel = play_sel_r;

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Schedules game sound events onto the single shared sample-table tone player. Latches one-cycle event pulses from the game logic, keeps them pending, and starts them one at a time by fixed priority. Higher-priority events pre-empt a playing sound, and a looping background sound (waka) fills idle time. Sits between the game FSM and the tone player; the player only sees `play_sel`, `play_start` and `play_abort`.

## Interface
- `NSRC`, 8, number of event sources; index 0 is the highest priority.
- `SELW`, 3, width of `play_sel`; NSRC ≤ 2^SELW.
- `BG_SEL`, 7, selector value used for the background loop.
- `GAP_CYCLES`, 4535, silent cycles between sounds (one 22.05 kHz sample period at 100 MHz).
- `TIMEOUT`, 24'hFFFFFF, maximum cycles in PLAY before a forced abort.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `ev_req`  in  NSRC  one-cycle event pulses; bit i requests sound i.
- `bg_en`  in  1  level; enables the background loop.
- `mute`  in  1  level; silences the block and discards requests.
- `player_done`  in  1  one-cycle pulse from the player at the end of its table.
- `play_start`  out  1  one-cycle start pulse to the player.
- `play_abort`  out  1  one-cycle stop pulse to the player.
- `play_sel`  out  SELW  sound selector; stable from START until the next IDLE selection.
- `busy`  out  1  high in START, PLAY, ABORT and GAP.
- `pending`  out  NSRC  latched, not-yet-started requests.
- `drop_cnt`  out  8  saturating count of coalesced requests.

## Operation
- **Pending register.** Each edge: `pending[i]` is set by `ev_req[i]` and cleared when source i is selected. If set and clear happen on the same edge, set wins and the sound replays later. While `mute` is high, `pending` is forced to 0 and `ev_req` is ignored.
- **drop_cnt.** Increments by 1 on an edge where `ev_req[i] & pending[i]` and bit i is not being cleared. If several bits qualify on one edge, it still increments by 1. Saturates at 255.
- **State IDLE.**
  - If `!mute` and `pending != 0`: select the lowest set index, load `play_sel`, clear that bit, set `cur_bg=0`, go to START.
  - Else if `!mute & bg_en`: load `play_sel=BG_SEL`, set `cur_bg=1`, go to START.
  - Else stay in IDLE.
- **State START.** `play_start=1` for this cycle. Clear the watchdog. Go to PLAY.
- **State PLAY.** Conditions are evaluated in this order:
  - `player_done`: go to GAP. If `cur_bg=1` the loop repeats through GAP and IDLE.
  - `mute`: go to ABORT.
  - `cur_bg=1` and (`pending != 0` or `!bg_en`): go to ABORT.
  - `cur_bg=0` and any `pending[j]` with j < current index: go to ABORT. Equal or lower priority never pre-empts.
  - Watchdog reaches `TIMEOUT`: go to ABORT.
- **State ABORT.** `play_abort=1` for this cycle. Go to GAP. A sound aborted by pre-emption or timeout is not re-queued.
- **State GAP.** Count `GAP_CYCLES` cycles, then go to IDLE. New requests keep latching during GAP.
- **Simultaneous events.**
  - `player_done` together with a pre-emption request: done wins; no abort is issued.
  - `player_done` outside PLAY is ignored.
- **Widths.** Gap counter is 13 bits and the watchdog is 24 bits; both compare with `>=` against parameters.

## Timing
- **Reset values.** State IDLE; `play_start`, `play_abort`, `busy`, `pending`, `drop_cnt`, `play_sel`, `cur_bg` and both counters all 0. Reset mid-sound returns to IDLE within one edge and issues no abort pulse.
- **Outputs.** `play_start`, `play_abort` and `busy` are Moore outputs decoded from registered state.
- **Start latency.** `ev_req` sampled at edge k (block idle) → `pending` set after k → START entered at edge k+1 → `play_start` high for the cycle after edge k+1.
- **Pre-emption latency.** Request sampled at edge k during PLAY → ABORT entered at edge k+2 (pending visible at k+1, decision at k+2).
- **Gap length.** Exactly `GAP_CYCLES` cycles in GAP, then 1 IDLE cycle, before the next START.

## Test plan
- `ev_req=8'h08` for one cycle → `play_start` 2 cycles later with `play_sel=3`. `player_done` pulse → GAP for 4535 cycles → IDLE with `busy=0`.
- `ev_req=8'h24` on a single edge → sound 2 plays first. After its done and the gap, sound 5 starts with no abort in between.
- Sound 4 playing, `ev_req[1]` pulse → `play_abort` 2 cycles later. After the gap, `play_sel=1` and `play_start`. `ev_req[6]` during sound 4 instead → no abort.
- `bg_en=1` with nothing pending → `play_sel=7` loops, with a gap after each done. `ev_req[0]` → abort, then sound 0, then the loop resumes. Dropping `bg_en` mid-loop → abort, then IDLE.
- `mute` asserted during PLAY → abort within 1 cycle, `pending` reads 0, `ev_req` pulses ignored, no start until `mute` falls.
- `ev_req[2]` pulsed 300 times while bit 2 stays pending → `drop_cnt=255`. With `TIMEOUT=100` and no done → `play_abort` exactly 100 cycles after PLAY is entered.
